// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master: the controller (reads instruction fields/flags, drives enables and selects).
// slave: the datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, illegal_op
  );

  modport slave (
    output op, funct3, funct7, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal).
// Moore outputs per state; imm_src/alu_control also follow the instruction fields and
// pc_write also follows the ALU zero flag.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes park the FSM in a TRAP state that
// raises illegal_op until reset. Without it they fall back to FETCH as a nop.
module multicycle_controller #(
  parameter int unsigned FETCH_WAIT = 0  // extra FETCH cycles before capture, 0..15
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] FetchLast = FETCH_WAIT[3:0];

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal
`ifdef ILLEGAL_TRAP_EN
    , StTrap
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       fetch_last;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  // Only funct7[5] matters for this subset.
  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  assign fetch_last = (wait_q == FetchLast);

  // State and fetch-wait counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; the wait counter only runs while held in FETCH.
  always_comb begin
    state_d = state_q;
    wait_d  = 4'd0;
    unique case (state_q)
      StFetch: begin
        if (fetch_last) state_d = StDecode;
        else            wait_d  = wait_q + 4'd1;
      end
      StDecode: begin
        unique case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
`ifdef ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;  // nop: PC already advanced in FETCH
`endif
        endcase
      end
      StMemAdr:   state_d = bus.op[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
`ifdef ILLEGAL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  // Moore decode of the datapath enables and mux selects.
  always_comb begin
    pc_update      = 1'b0;
    branch         = 1'b0;
    alu_op         = 2'b00;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.reg_write  = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = fetch_last;
        pc_update      = fetch_last;
      end
      StDecode: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      StMemRead: bus.adr_src = 1'b1;
      StMemWb: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      StMemWrite: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      StExecR: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b10;
      end
      StExecI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        alu_op        = 2'b10;
      end
      StAluWb: bus.reg_write = 1'b1;
      StBeq: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b01;
        branch        = 1'b1;
      end
      StJal: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
      end
      default: ;  // TRAP (when present) keeps every enable low
    endcase
  end

  assign bus.pc_write = pc_update | (branch & bus.zero);

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_op = (state_q == StTrap);
`else
  assign bus.illegal_op = 1'b0;
`endif

  // Immediate format from the opcode alone.
  always_comb begin
    bus.imm_src = 2'b00;
    unique case (bus.op)
      OpStore: bus.imm_src = 2'b01;
      OpBeq:   bus.imm_src = 2'b10;
      OpJal:   bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

  // ALU control decode; unsupported funct3 falls back to add.
  always_comb begin
    bus.alu_control = 3'b000;
    unique case (alu_op)
      2'b01: bus.alu_control = 3'b001;
      2'b10: begin
        unique case (bus.funct3)
          3'b000:  bus.alu_control = (bus.funct7[5] & bus.op[5]) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
      default: bus.alu_control = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance with FETCH_WAIT=0, one with 3.
// Each cycle's full output word is compared against hand-built expected words.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller_if bus0 ();
  multicycle_controller_if bus3 ();

  multicycle_controller #(.FETCH_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  multicycle_controller #(.FETCH_WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Output word: {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
  //               alu_control, imm_src, reg_write, illegal_op}
  logic [16:0] v0, v3;
  assign v0 = {bus0.pc_write, bus0.adr_src, bus0.mem_write, bus0.ir_write, bus0.result_src,
               bus0.alu_src_a, bus0.alu_src_b, bus0.alu_control, bus0.imm_src,
               bus0.reg_write, bus0.illegal_op};
  assign v3 = {bus3.pc_write, bus3.adr_src, bus3.mem_write, bus3.ir_write, bus3.result_src,
               bus3.alu_src_a, bus3.alu_src_b, bus3.alu_control, bus3.imm_src,
               bus3.reg_write, bus3.illegal_op};

  logic [16:0] exp_q[$];

  function automatic logic [16:0] pk(bit pcw, bit adr, bit mw, bit irw, logic [1:0] rs,
                                     logic [1:0] a, logic [1:0] b, logic [2:0] ac,
                                     logic [1:0] imm, bit rw, bit ill);
    return {pcw, adr, mw, irw, rs, a, b, ac, imm, rw, ill};
  endfunction

  // Common state words for a given imm_src.
  function automatic logic [16:0] w_fetch_last(logic [1:0] imm);
    return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] w_fetch_hold(logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] w_decode(logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] w_memadr(logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] w_aluwb(logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic z);
    bus0.op = op; bus0.funct3 = f3; bus0.funct7 = f7; bus0.zero = z;
    bus3.op = op; bus3.funct3 = f3; bus3.funct7 = f7; bus3.zero = z;
  endtask

  // Leaves us at a falling edge with rst just released; FETCH cycle 0 is current.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare exp_q entries one per cycle, sampled 1 time unit after the falling edge.
  task automatic run_seq(string tag, bit sel3);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_eq($sformatf("%s c%0d", tag, i), {15'd0, sel3 ? v3 : v0}, {15'd0, exp_q[i]});
    end
  endtask

  logic [2:0] r_f3  [6] = '{3'b000, 3'b000, 3'b110, 3'b111, 3'b010, 3'b001};
  logic [6:0] r_f7  [6] = '{7'b0100000, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0};
  logic [2:0] r_ac  [6] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b101, 3'b000};
  logic [2:0] i_f3  [2] = '{3'b000, 3'b010};
  logic [2:0] i_ac  [2] = '{3'b000, 3'b101};

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state: FETCH words while rst is held.
    set_in(7'b0000011, 3'b010, 7'b0, 1'b0);
    #2;
    check_eq("reset dut0", {15'd0, v0}, {15'd0, w_fetch_last(2'b00)});
    check_eq("reset dut3", {15'd0, v3}, {15'd0, w_fetch_hold(2'b00)});

    // lw: FETCH DECODE MEMADR MEMREAD MEMWB FETCH
    apply_reset();
    exp_q = {w_fetch_last(2'b00), w_decode(2'b00), w_memadr(2'b00),
             pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0),
             pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0),
             w_fetch_last(2'b00)};
    run_seq("lw", 0);

    // R-type variants through EXECR
    for (int k = 0; k < 6; k++) begin
      set_in(7'b0110011, r_f3[k], r_f7[k], 1'b0);
      apply_reset();
      exp_q = {w_fetch_last(2'b00), w_decode(2'b00),
               pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, r_ac[k], 2'b00, 0, 0),
               w_aluwb(2'b00), w_fetch_last(2'b00)};
      run_seq($sformatf("rtype%0d", k), 0);
    end

    // I-type with funct7[5] set: addi must stay add, slti gives slt
    for (int k = 0; k < 2; k++) begin
      set_in(7'b0010011, i_f3[k], 7'b0100000, 1'b0);
      apply_reset();
      exp_q = {w_fetch_last(2'b00), w_decode(2'b00),
               pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, i_ac[k], 2'b00, 0, 0),
               w_aluwb(2'b00), w_fetch_last(2'b00)};
      run_seq($sformatf("itype%0d", k), 0);
    end

    // beq taken and not taken, 3 cycles each
    for (int z = 1; z >= 0; z--) begin
      set_in(7'b1100011, 3'b000, 7'b0, z[0]);
      apply_reset();
      exp_q = {w_fetch_last(2'b10), w_decode(2'b10),
               pk(z[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0),
               w_fetch_last(2'b10)};
      run_seq($sformatf("beq z%0d", z), 0);
    end

    // jal: FETCH DECODE JAL ALUWB FETCH, imm_src=11 throughout
    set_in(7'b1101111, 3'b000, 7'b0, 1'b0);
    apply_reset();
    exp_q = {w_fetch_last(2'b11), w_decode(2'b11),
             pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0),
             w_aluwb(2'b11), w_fetch_last(2'b11)};
    run_seq("jal", 0);

    // sw with FETCH_WAIT=3: 4 FETCH cycles, 7 total, one mem_write cycle
    set_in(7'b0100011, 3'b010, 7'b0, 1'b0);
    apply_reset();
    exp_q = {w_fetch_hold(2'b01), w_fetch_hold(2'b01), w_fetch_hold(2'b01),
             w_fetch_last(2'b01), w_decode(2'b01), w_memadr(2'b01),
             pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0),
             w_fetch_hold(2'b01)};
    run_seq("sw_w3", 1);

    // Unsupported opcode
    set_in(7'b1111111, 3'b000, 7'b0, 1'b0);
    apply_reset();
`ifdef ILLEGAL_TRAP_EN
    exp_q = {w_fetch_last(2'b00), w_decode(2'b00),
             pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1),
             pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1),
             pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1),
             pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1)};
`else
    exp_q = {w_fetch_last(2'b00), w_decode(2'b00), w_fetch_last(2'b00),
             w_decode(2'b00), w_fetch_last(2'b00)};
`endif
    run_seq("illegal", 0);

    // Later sw on dut0, reset asserted during MEMWRITE
    set_in(7'b0100011, 3'b010, 7'b0, 1'b0);
    apply_reset();
    exp_q = {w_fetch_last(2'b01), w_decode(2'b01), w_memadr(2'b01),
             pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0)};
    run_seq("sw_abort", 0);
    #1 rst = 1'b1;
    #1;
    check_eq("abort mem_write", {31'd0, bus0.mem_write}, 32'd0);
    check_eq("abort state", {15'd0, v0}, {15'd0, w_fetch_last(2'b01)});
    @(negedge clk);
    rst = 1'b0;
    exp_q = {w_fetch_last(2'b01), w_decode(2'b01)};
    run_seq("after_abort", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
